// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc_pkg
// Purpose  : Shared FSM encoding, BLE CRC constants and the LFSR step function.
// Revision : 1.0 - initial release
// ============================================================================
package crc_pkg;

    localparam int C_CRC_MAX_W = 32;

    typedef logic [1:0] crc_fsm_t;
    localparam crc_fsm_t C_ST_IDLE   = 2'd0;
    localparam crc_fsm_t C_ST_DATA   = 2'd1;
    localparam crc_fsm_t C_ST_APPEND = 2'd2;

    localparam logic [23:0] BLE_CRC_POLY     = 24'h00065B;
    localparam logic [23:0] BLE_ADV_CRC_INIT = 24'h555555;

    // Operands are MSB-aligned in a C_CRC_MAX_W vector so one function serves any W <= 32.
    function automatic logic [C_CRC_MAX_W-1:0] crc_step(
        input logic [C_CRC_MAX_W-1:0] state,
        input logic                   data_bit,
        input logic [C_CRC_MAX_W-1:0] poly
    );
        logic fb;
        fb       = state[C_CRC_MAX_W-1] ^ data_bit;
        crc_step = {state[C_CRC_MAX_W-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : crc_engine_if
// Purpose  : Bit-stream, control and status bundle of the CRC engine.
// Revision : 1.0 - initial release
// ============================================================================
interface crc_engine_if #(
    parameter int W = 24
);
    logic [W-1:0] crc_state_init_bit;
    logic         crc_state_init_bit_load;
    logic         mode;
    logic         info_bit;
    logic         info_bit_valid;
    logic         info_bit_valid_last;
    logic         info_bit_ready;
    logic         info_bit_after_crc;
    logic         info_bit_after_crc_valid;
    logic         info_bit_after_crc_valid_last;
    logic         crc_check_done;
    logic         crc_check_ok;
    logic [W-1:0] crc_state;

    modport master (
        output crc_state_init_bit, crc_state_init_bit_load, mode,
               info_bit, info_bit_valid, info_bit_valid_last,
        input  info_bit_ready, info_bit_after_crc, info_bit_after_crc_valid,
               info_bit_after_crc_valid_last, crc_check_done, crc_check_ok, crc_state
    );

    modport slave (
        input  crc_state_init_bit, crc_state_init_bit_load, mode,
               info_bit, info_bit_valid, info_bit_valid_last,
        output info_bit_ready, info_bit_after_crc, info_bit_after_crc_valid,
               info_bit_after_crc_valid_last, crc_check_done, crc_check_ok, crc_state
    );
endinterface
`default_nettype wire

// File: rtl/crc_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : crc_lfsr
// Purpose  : W-bit CRC register with load, data-fed step and zero-fed shift-out.
// Revision : 1.0 - initial release
// ============================================================================
module crc_lfsr
    import crc_pkg::*;
#(
    parameter int           W        = 24,
    parameter logic [W-1:0] CRC_POLY = W'(BLE_CRC_POLY)
)(
    input  wire          clk,
    input  wire          rst,
    input  wire          i_load,
    input  wire  [W-1:0] i_init,
    input  wire          i_step,
    input  wire          i_data_bit,
    input  wire          i_shift,
    output logic [W-1:0] o_state,
    output logic [W-1:0] o_state_next
);

    localparam int                     c_pad     = C_CRC_MAX_W - W;
    localparam logic [C_CRC_MAX_W-1:0] c_poly_al = C_CRC_MAX_W'(CRC_POLY) << c_pad;

    logic [W-1:0]           r_state;
    logic [C_CRC_MAX_W-1:0] w_state_al;
    logic [C_CRC_MAX_W-1:0] w_step_al;

    assign w_state_al   = C_CRC_MAX_W'(r_state) << c_pad;
    assign w_step_al    = crc_step(w_state_al, i_data_bit, c_poly_al);
    assign o_state_next = W'(w_step_al >> c_pad);
    assign o_state      = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_init;
        end else if (i_step) begin
            r_state <= o_state_next;
        end else if (i_shift) begin
            r_state <= {r_state[W-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/crc_engine.sv
`default_nettype none
// ============================================================================
// Module   : crc_engine
// Purpose  : Bit-serial CRC generator/appender and checker with paced CRC output.
// Revision : 1.0 - initial release
// ============================================================================
module crc_engine
    import crc_pkg::*;
#(
    parameter int                             CRC_STATE_BIT_WIDTH = 24,
    parameter logic [CRC_STATE_BIT_WIDTH-1:0] CRC_POLY            = CRC_STATE_BIT_WIDTH'(BLE_CRC_POLY),
    parameter int                             APPEND_GAP          = 16
)(
    input wire          clk,
    input wire          rst,
    crc_engine_if.slave bus
);

    localparam int                   c_w          = CRC_STATE_BIT_WIDTH;
    localparam int                   c_gap_w      = $clog2(APPEND_GAP + 1);
    localparam int                   c_bit_w      = $clog2(c_w + 1);
    localparam logic [c_gap_w-1:0]   c_gap_reload = c_gap_w'(APPEND_GAP - 1);
    localparam logic [c_bit_w-1:0]   c_bit_last   = c_bit_w'(c_w - 1);

    crc_fsm_t            r_fsm;
    crc_fsm_t            w_fsm_next;
    logic                r_mode;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic [c_bit_w-1:0]  r_bit_cnt;
    logic                r_out_bit;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_done;
    logic                r_ok;
    logic [c_w-1:0]      w_state;
    logic [c_w-1:0]      w_state_next;
    logic                w_ready;
    logic                w_accept;
    logic                w_accept_last;
    logic                w_check_end;
    logic                w_enter_append;
    logic                w_emit;
    logic                w_emit_last;

    crc_lfsr #(
        .W        (c_w),
        .CRC_POLY (CRC_POLY)
    ) u_lfsr (
        .clk          (clk),
        .rst          (rst),
        .i_load       (bus.crc_state_init_bit_load),
        .i_init       (bus.crc_state_init_bit),
        .i_step       (w_accept),
        .i_data_bit   (bus.info_bit),
        .i_shift      (w_emit),
        .o_state      (w_state),
        .o_state_next (w_state_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= C_ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // A load restarts the frame from any state, aborting whatever was in flight.
    always_comb begin
        w_fsm_next = r_fsm;
        if (bus.crc_state_init_bit_load) begin
            w_fsm_next = C_ST_DATA;
        end else begin
            case (r_fsm)
                C_ST_IDLE:   w_fsm_next = C_ST_IDLE;
                C_ST_DATA:   if (w_accept_last) w_fsm_next = r_mode ? C_ST_IDLE : C_ST_APPEND;
                C_ST_APPEND: if (w_emit_last)   w_fsm_next = C_ST_IDLE;
                default:     w_fsm_next = C_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ready        = (r_fsm == C_ST_DATA);
        w_accept       = w_ready && bus.info_bit_valid && !bus.crc_state_init_bit_load;
        w_accept_last  = w_accept && bus.info_bit_valid_last;
        w_check_end    = w_accept_last && r_mode;
        w_enter_append = w_accept_last && !r_mode;
        w_emit         = (r_fsm == C_ST_APPEND) && (r_gap_cnt == '0) && !bus.crc_state_init_bit_load;
        w_emit_last    = w_emit && (r_bit_cnt == c_bit_last);
    end

    // Gap counter is preloaded so the first CRC bit lands APPEND_GAP cycles after the last echo.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= 1'b0;
            r_gap_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (bus.crc_state_init_bit_load) begin
                r_mode <= bus.mode;
            end
            if (bus.crc_state_init_bit_load || w_enter_append) begin
                r_gap_cnt <= c_gap_reload;
                r_bit_cnt <= '0;
            end else if (r_fsm == C_ST_APPEND) begin
                if (r_gap_cnt == '0) begin
                    r_gap_cnt <= c_gap_reload;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end else begin
                    r_gap_cnt <= r_gap_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_ok        <= 1'b0;
        end else if (bus.crc_state_init_bit_load) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_ok        <= 1'b0;
        end else if (w_accept) begin
            r_out_bit   <= bus.info_bit;
            r_out_valid <= 1'b1;
            r_out_last  <= w_check_end;
            r_done      <= w_check_end;
            if (w_check_end) begin
                r_ok <= (w_state_next == '0);
            end
        end else if (w_emit) begin
            r_out_bit   <= w_state[c_w-1];
            r_out_valid <= 1'b1;
            r_out_last  <= w_emit_last;
            r_done      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end
    end

    assign bus.info_bit_ready                = w_ready;
    assign bus.info_bit_after_crc            = r_out_bit;
    assign bus.info_bit_after_crc_valid      = r_out_valid;
    assign bus.info_bit_after_crc_valid_last = r_out_last;
    assign bus.crc_check_done                = r_done;
    assign bus.crc_check_ok                  = r_ok;
    assign bus.crc_state                     = w_state;

endmodule
`default_nettype wire

// File: tb/tb_crc_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_engine
// Purpose  : Directed self-checking bench for crc_engine (APPEND_GAP 16 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_engine;
    import crc_pkg::*;

    typedef struct {
        int   cyc;
        logic b;
        logic last;
        logic done;
        logic ok;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0;
    int   n;
    ev_t  qa[$];
    ev_t  qb[$];

    crc_engine_if #(.W(24)) ia ();
    crc_engine_if #(.W(24)) ib ();

    crc_engine #(
        .CRC_STATE_BIT_WIDTH (24),
        .CRC_POLY            (24'h00065B),
        .APPEND_GAP          (16)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    crc_engine #(
        .CRC_STATE_BIT_WIDTH (24),
        .CRC_POLY            (24'h00065B),
        .APPEND_GAP          (1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ia.info_bit_after_crc_valid === 1'b1)
            qa.push_back('{cyc, ia.info_bit_after_crc, ia.info_bit_after_crc_valid_last,
                           ia.crc_check_done, ia.crc_check_ok});
        if (ib.info_bit_after_crc_valid === 1'b1)
            qb.push_back('{cyc, ib.info_bit_after_crc, ib.info_bit_after_crc_valid_last,
                           ib.crc_check_done, ib.crc_check_ok});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int cnt);
        repeat (cnt) tick();
    endtask

    task automatic load_a(input logic [23:0] init, input logic m);
        ia.crc_state_init_bit      = init;
        ia.mode                    = m;
        ia.crc_state_init_bit_load = 1'b1;
        tick();
        ia.crc_state_init_bit_load = 1'b0;
    endtask

    task automatic send_a(input logic b, input logic last);
        ia.info_bit            = b;
        ia.info_bit_valid      = 1'b1;
        ia.info_bit_valid_last = last;
        tick();
        ia.info_bit_valid      = 1'b0;
        ia.info_bit_valid_last = 1'b0;
    endtask

    // Echo at t0, then 24 CRC bits at t0+gap*k with valid_last only on the final one.
    task automatic check_gen(input string tag, input ev_t q[$], input int ts, input int gap,
                             input logic echo, input logic [23:0] crc);
        logic [23:0] bits;
        logic [24:0] lastv;
        int          pos_err;
        bits    = '0;
        lastv   = '0;
        pos_err = 0;
        chk({tag, "_count"}, 32'(q.size()), 32'd25);
        if (q.size() == 25) begin
            for (int k = 0; k < 25; k++) begin
                lastv = {lastv[23:0], q[k].last};
                if (q[k].cyc != ts + gap * k) pos_err++;
                if (k > 0) bits = {bits[22:0], q[k].b};
            end
            chk({tag, "_echo"}, {31'd0, q[0].b}, {31'd0, echo});
            chk({tag, "_crc_bits"}, {8'd0, bits}, {8'd0, crc});
            chk({tag, "_timing_errs"}, 32'(pos_err), 32'd0);
            chk({tag, "_last_mask"}, {7'd0, lastv}, 32'd1);
        end
    endtask

    initial begin
        ia.crc_state_init_bit = '0; ia.crc_state_init_bit_load = 1'b0; ia.mode = 1'b0;
        ia.info_bit = 1'b0; ia.info_bit_valid = 1'b0; ia.info_bit_valid_last = 1'b0;
        ib.crc_state_init_bit = '0; ib.crc_state_init_bit_load = 1'b0; ib.mode = 1'b0;
        ib.info_bit = 1'b0; ib.info_bit_valid = 1'b0; ib.info_bit_valid_last = 1'b0;

        // Reset state
        run_cycles(3);
        chk("rst_ready", {31'd0, ia.info_bit_ready}, 32'd0);
        chk("rst_valid", {31'd0, ia.info_bit_after_crc_valid}, 32'd0);
        chk("rst_state", {8'd0, ia.crc_state}, 32'd0);
        chk("rst_ok", {31'd0, ia.crc_check_ok}, 32'd0);
        rst = 1'b0;
        tick();

        // Generate, init 0, single bit 1
        load_a(24'h000000, 1'b0);
        chk("t1_ready", {31'd0, ia.info_bit_ready}, 32'd1);
        qa.delete();
        send_a(1'b1, 1'b1);
        t0 = cyc;
        chk("t1_echo_valid", {31'd0, ia.info_bit_after_crc_valid}, 32'd1);
        chk("t1_echo_last", {31'd0, ia.info_bit_after_crc_valid_last}, 32'd0);
        chk("t1_state", {8'd0, ia.crc_state}, 32'h00065B);
        tick();
        chk("t1_ready_append", {31'd0, ia.info_bit_ready}, 32'd0);
        run_cycles(24 * 16 + 4);
        check_gen("t1", qa, t0, 16, 1'b1, 24'h00065B);
        chk("t1_state_drained", {8'd0, ia.crc_state}, 32'd0);

        // Generate, BLE advertising init, single bit 0
        load_a(BLE_ADV_CRC_INIT, 1'b0);
        qa.delete();
        send_a(1'b0, 1'b1);
        t0 = cyc;
        chk("t2_state", {8'd0, ia.crc_state}, 32'hAAAAAA);
        run_cycles(24 * 16 + 4);
        check_gen("t2", qa, t0, 16, 1'b0, 24'hAAAAAA);

        // Check mode: good CRC, then one flipped CRC bit
        for (int f = 0; f < 2; f++) begin
            logic [23:0] v;
            logic [24:0] dmask;
            v     = 24'h00065B ^ ((f == 1) ? 24'h000001 : 24'h000000);
            dmask = '0;
            load_a(24'h000000, 1'b1);
            qa.delete();
            send_a(1'b1, 1'b0);
            for (int i = 23; i >= 0; i--) send_a(v[i], i == 0);
            chk($sformatf("t3_%0d_last", f), {31'd0, ia.info_bit_after_crc_valid_last}, 32'd1);
            chk($sformatf("t3_%0d_done", f), {31'd0, ia.crc_check_done}, 32'd1);
            chk($sformatf("t3_%0d_ok", f), {31'd0, ia.crc_check_ok}, (f == 0) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("t3_%0d_done_pulse", f), {31'd0, ia.crc_check_done}, 32'd0);
            chk($sformatf("t3_%0d_ok_held", f), {31'd0, ia.crc_check_ok}, (f == 0) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("t3_%0d_count", f), 32'(qa.size()), 32'd25);
            foreach (qa[k]) dmask = {dmask[23:0], qa[k].done};
            chk($sformatf("t3_%0d_done_mask", f), {7'd0, dmask}, 32'd1);
        end

        // Load mid-APPEND after the 5th CRC bit
        load_a(24'h000000, 1'b0);
        qa.delete();
        send_a(1'b1, 1'b1);
        n = 0;
        while (qa.size() < 6 && n < 200) begin
            tick();
            n++;
        end
        chk("t4_reached_5", 32'(qa.size()), 32'd6);
        load_a(24'h000000, 1'b0);
        chk("t4_ready", {31'd0, ia.info_bit_ready}, 32'd1);
        run_cycles(400);
        chk("t4_no_more_bits", 32'(qa.size()), 32'd6);
        n = 0;
        foreach (qa[k]) if (qa[k].last) n++;
        chk("t4_no_last", 32'(n), 32'd0);
        qa.delete();
        send_a(1'b1, 1'b1);
        t0 = cyc;
        run_cycles(24 * 16 + 4);
        check_gen("t4_new", qa, t0, 16, 1'b1, 24'h00065B);

        // Asynchronous reset mid-DATA
        load_a(24'h000000, 1'b1);
        send_a(1'b1, 1'b0);
        send_a(1'b0, 1'b0);
        chk("t5_pre_valid", {31'd0, ia.info_bit_after_crc_valid}, 32'd1);
        chk("t5_pre_state", {8'd0, ia.crc_state}, 32'h000CB6);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_valid", {31'd0, ia.info_bit_after_crc_valid}, 32'd0);
        chk("t5_rst_ready", {31'd0, ia.info_bit_ready}, 32'd0);
        chk("t5_rst_state", {8'd0, ia.crc_state}, 32'd0);
        tick();
        rst = 1'b0;
        qa.delete();
        ia.info_bit = 1'b1;
        ia.info_bit_valid = 1'b1;
        run_cycles(3);
        ia.info_bit_valid = 1'b0;
        tick();
        chk("t5_ignored_count", 32'(qa.size()), 32'd0);
        chk("t5_ignored_state", {8'd0, ia.crc_state}, 32'd0);

        // APPEND_GAP=1, back-to-back bits, load coincident with a valid
        ib.crc_state_init_bit = 24'h000000;
        ib.mode = 1'b0;
        ib.crc_state_init_bit_load = 1'b1;
        tick();
        ib.crc_state_init_bit_load = 1'b0;
        qb.delete();
        ib.info_bit = 1'b1;
        ib.info_bit_valid = 1'b1;
        run_cycles(2);
        ib.crc_state_init_bit_load = 1'b1;
        tick();
        ib.crc_state_init_bit_load = 1'b0;
        ib.info_bit_valid = 1'b0;
        ib.info_bit_valid_last = 1'b1;
        tick();
        chk("t6_last_no_valid", {31'd0, ib.info_bit_ready}, 32'd1);
        ib.info_bit_valid = 1'b1;
        tick();
        t0 = cyc;
        ib.info_bit_valid = 1'b0;
        ib.info_bit_valid_last = 1'b0;
        chk("t6_state", {8'd0, ib.crc_state}, 32'h00065B);
        run_cycles(30);
        chk("t6_count", 32'(qb.size()), 32'd27);
        if (qb.size() == 27) begin
            chk("t6_pre_echo", {30'd0, qb[0].b, qb[1].b}, 32'd3);
            void'(qb.pop_front());
            void'(qb.pop_front());
        end
        check_gen("t6", qb, t0, 1, 1'b1, 24'h00065B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
